// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB codes and transfer helpers for the SRAM responder
`ifndef AW
`define AW 32
`endif
`ifndef DW
`define DW 32
`endif

package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_e;

    // Oversized or misaligned transfers are answered with ERROR.
    function automatic logic is_illegal(input logic [2:0] size, input logic [1:0] addr_lsb);
        return (size > 3'd2) ||
               (size == 3'd2 && addr_lsb != 2'b00) ||
               (size == 3'd1 && addr_lsb[0]);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
        case (size)
            3'd0:    return 4'b0001 << off;
            3'd1:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_responder_if.sv
// rtl/ahb_sram_responder_if.sv - AHB slave-port bundle with master/slave views
`ifndef AW
`define AW 32
`endif
`ifndef DW
`define DW 32
`endif

interface ahb_sram_responder_if;
    logic             HSEL;
    logic [`AW-1:0]   HADDR;
    logic [1:0]       HTRANS;
    logic             HWRITE;
    logic [2:0]       HSIZE;
    logic [2:0]       HBURST;
    logic [3:0]       HPROT;
    logic [`DW-1:0]   HWDATA;
    logic             HREADY;
    logic             HREADYOUT;
    logic [1:0]       HRESP;
    logic [`DW-1:0]   HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_slv_mem.sv
// rtl/ahb_slv_mem.sv - byte-lane word memory, per-lane write enable, async read
`ifndef DW
`define DW 32
`endif

module ahb_slv_mem #(
    parameter int P_WORDS = 256,
    parameter int P_WAW   = 8
) (
    input  logic             HCLK,
    input  logic [3:0]       we,
    input  logic [P_WAW-1:0] addr,
    input  logic [`DW-1:0]   wdata,
    output logic [`DW-1:0]   rdata
);
    logic [`DW-1:0] mem [P_WORDS];

    always_ff @(posedge HCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/ahb_sram_responder.sv
// rtl/ahb_sram_responder.sv - AHB SRAM slave with configurable wait states and two-cycle ERROR
module ahb_sram_responder
    import ahb_pkg::*;
#(
    parameter int P_SIZE_IN_BYTES = 1024,
    parameter int P_WAIT_NSEQ     = 0,
    parameter int P_WAIT_SEQ      = 0
) (
    input  logic HCLK,
    input  logic HRESETn,
    ahb_sram_responder_if.slave bus
);
    localparam int OW    = $clog2(P_SIZE_IN_BYTES);
    localparam int WORDS = P_SIZE_IN_BYTES / 4;
    localparam int WAW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0] WAIT_N = 4'(P_WAIT_NSEQ);
    localparam logic [3:0] WAIT_S = 4'(P_WAIT_SEQ);

    state_e          state;
    logic [3:0]      cnt;
    logic [OW-1:0]   off_q;
    logic            wr_q;
    logic [2:0]      size_q;
    logic            accept;
    logic            illegal;
    logic [3:0]      wait_n;
    logic [WAW-1:0]  word_addr;
    logic [3:0]      we;
    logic [`DW-1:0]  rdata;
    logic            unused_ok;

    // Address phases are only sampled while no data phase is stalling the bus.
    assign accept  = bus.HSEL && bus.HTRANS[1] && bus.HREADY &&
                     (state == S_IDLE || state == S_DATA || state == S_ERR2);
    assign illegal = is_illegal(bus.HSIZE, bus.HADDR[1:0]);
    assign wait_n  = bus.HTRANS[0] ? WAIT_S : WAIT_N;

    assign word_addr  = WAW'(off_q >> 2);
    assign we         = (state == S_DATA && wr_q) ? lane_mask(size_q, off_q[1:0]) : 4'b0000;
    assign bus.HRDATA = (state == S_DATA && !wr_q) ? rdata : '0;
    assign unused_ok  = &{1'b0, bus.HBURST, bus.HPROT, bus.HADDR};

    ahb_slv_mem #(
        .P_WORDS (WORDS),
        .P_WAW   (WAW)
    ) u_mem (
        .HCLK  (HCLK),
        .we    (we),
        .addr  (word_addr),
        .wdata (bus.HWDATA),
        .rdata (rdata)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state         <= S_IDLE;
            cnt           <= '0;
            off_q         <= '0;
            wr_q          <= 1'b0;
            size_q        <= '0;
            bus.HREADYOUT <= 1'b1;
            bus.HRESP     <= HRESP_OKAY;
        end else begin
            case (state)
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state         <= S_DATA;
                        bus.HREADYOUT <= 1'b1;
                    end
                end
                S_ERR1: begin
                    state         <= S_ERR2;
                    bus.HREADYOUT <= 1'b1;
                    bus.HRESP     <= HRESP_ERROR;
                end
                default: begin
                    if (accept) begin
                        off_q  <= bus.HADDR[OW-1:0];
                        wr_q   <= bus.HWRITE;
                        size_q <= bus.HSIZE;
                        if (illegal) begin
                            state         <= S_ERR1;
                            bus.HREADYOUT <= 1'b0;
                            bus.HRESP     <= HRESP_ERROR;
                        end else if (wait_n == 4'd0) begin
                            state         <= S_DATA;
                            bus.HREADYOUT <= 1'b1;
                            bus.HRESP     <= HRESP_OKAY;
                        end else begin
                            state         <= S_WAIT;
                            cnt           <= wait_n;
                            bus.HREADYOUT <= 1'b0;
                            bus.HRESP     <= HRESP_OKAY;
                        end
                    end else begin
                        state         <= S_IDLE;
                        bus.HREADYOUT <= 1'b1;
                        bus.HRESP     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_sram_responder.sv
// tb/tb_ahb_sram_responder.sv - self-checking bench for the AHB SRAM responder
module tb_ahb_sram_responder;
    import ahb_pkg::*;

    logic hclk = 1'b0;
    logic hresetn = 1'b1;
    always #5 hclk = ~hclk;

    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    int          dsel;

    ahb_sram_responder_if bus0();
    ahb_sram_responder_if bus1();

    assign bus0.HSEL   = hsel && (dsel == 0);
    assign bus1.HSEL   = hsel && (dsel == 1);
    assign bus0.HADDR  = haddr;   assign bus1.HADDR  = haddr;
    assign bus0.HTRANS = htrans;  assign bus1.HTRANS = htrans;
    assign bus0.HWRITE = hwrite;  assign bus1.HWRITE = hwrite;
    assign bus0.HSIZE  = hsize;   assign bus1.HSIZE  = hsize;
    assign bus0.HBURST = hburst;  assign bus1.HBURST = hburst;
    assign bus0.HPROT  = 4'b0011; assign bus1.HPROT  = 4'b0011;
    assign bus0.HWDATA = hwdata;  assign bus1.HWDATA = hwdata;
    assign bus0.HREADY = bus0.HREADYOUT;
    assign bus1.HREADY = bus1.HREADYOUT;

    ahb_sram_responder #(.P_SIZE_IN_BYTES(1024), .P_WAIT_NSEQ(0), .P_WAIT_SEQ(0)) u_dut0 (
        .HCLK(hclk), .HRESETn(hresetn), .bus(bus0.slave));
    ahb_sram_responder #(.P_SIZE_IN_BYTES(1024), .P_WAIT_NSEQ(2), .P_WAIT_SEQ(1)) u_dut1 (
        .HCLK(hclk), .HRESETn(hresetn), .bus(bus1.slave));

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] wdata;
        logic [1:0]  trans;
    } beat_t;

    typedef struct {
        logic        rdy;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        commit;
        logic        is_rd;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } exp_t;

    beat_t       bq[$];
    exp_t        eq[$];
    logic [7:0]  mdl [2][1024];
    int          checks = 0;
    int          errors = 0;
    int          low_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] last_rd = '0;
    logic [31:0] last_act = '0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", n, act, req);
        end
    endtask

    function automatic logic [31:0] mdl_word(input int s, input logic [31:0] a);
        int base;
        base = int'(a % 1024) & ~3;
        return {mdl[s][base+3], mdl[s][base+2], mdl[s][base+1], mdl[s][base]};
    endfunction

    task automatic mdl_commit(input int s, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        int base;
        int lane;
        base = int'(a % 1024);
        for (int i = 0; i < (1 << sz); i++) begin
            lane = (base % 4) + i;
            mdl[s][(base & ~3) + lane] = d[8*lane +: 8];
        end
    endtask

    // Expected per-cycle data-phase responses for one accepted beat.
    task automatic push(input int s, input beat_t b);
        exp_t e;
        int   w;
        logic bad;
        e = '{rdy: 1'b0, resp: 2'b00, rdata: '0, commit: 1'b0, is_rd: 1'b0,
              addr: '0, size: '0, wdata: '0};
        bad = (b.size > 3'd2) || ((b.addr % (32'd1 << b.size)) != 0);
        if (bad) begin
            e.resp = 2'b01;
            eq.push_back(e);
            e.rdy = 1'b1;
            eq.push_back(e);
        end else begin
            w = (s == 0) ? 0 : ((b.trans == 2'b11) ? 1 : 2);
            for (int i = 0; i < w; i++) eq.push_back(e);
            e.rdy = 1'b1;
            if (b.wr) begin
                e.commit = 1'b1;
                e.addr   = b.addr;
                e.size   = b.size;
                e.wdata  = b.wdata;
            end else begin
                e.is_rd = 1'b1;
                e.rdata = mdl_word(s, b.addr);
            end
            eq.push_back(e);
        end
    endtask

    always @(negedge hclk) begin
        exp_t        e;
        logic        a_rdy;
        logic [1:0]  a_resp;
        logic [31:0] a_rd;
        if (hresetn) begin
            for (int k = 0; k < 2; k++) begin
                e = '{rdy: 1'b1, resp: 2'b00, rdata: '0, commit: 1'b0, is_rd: 1'b0,
                      addr: '0, size: '0, wdata: '0};
                if (k == dsel && eq.size() > 0) e = eq.pop_front();
                a_rdy  = (k == 0) ? bus0.HREADYOUT : bus1.HREADYOUT;
                a_resp = (k == 0) ? bus0.HRESP     : bus1.HRESP;
                a_rd   = (k == 0) ? bus0.HRDATA    : bus1.HRDATA;
                chk($sformatf("dut%0d_hreadyout@%0t", k, $time), {31'd0, a_rdy}, {31'd0, e.rdy});
                chk($sformatf("dut%0d_hresp@%0t", k, $time), {30'd0, a_resp}, {30'd0, e.resp});
                chk($sformatf("dut%0d_hrdata@%0t", k, $time), a_rd, e.rdata);
                if (k == dsel) begin
                    if (a_rdy !== 1'b1) low_cnt++;
                    if (a_resp === 2'b01) err_cnt++;
                end
                if (e.commit) mdl_commit(k, e.addr, e.size, e.wdata);
                if (e.is_rd) begin
                    last_rd  = e.rdata;
                    last_act = a_rd;
                end
            end
        end
    end

    task automatic add(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                       input logic [31:0] d, input logic [1:0] tr);
        beat_t b;
        b = '{addr: a, size: sz, wr: wr, wdata: d, trans: tr};
        bq.push_back(b);
    endtask

    // Pipelined master: next address rides on the current data phase.
    task automatic run(input int s);
        beat_t b;
        logic  r;
        int    g;
        dsel = s;
        forever begin
            if (bq.size() > 0) begin
                b      = bq[0];
                hsel   = 1'b1;
                haddr  = b.addr;
                htrans = b.trans;
                hwrite = b.wr;
                hsize  = b.size;
            end else begin
                hsel   = 1'b0;
                htrans = HTRANS_IDLE;
            end
            g = 0;
            r = 1'b0;
            while (!r && g < 40) begin
                @(negedge hclk);
                r = (s == 0) ? bus0.HREADYOUT : bus1.HREADYOUT;
                @(posedge hclk);
                g++;
            end
            if (r !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL run_timeout: actual=no_ready required=ready_within_40");
                bq.delete();
                break;
            end
            if (bq.size() == 0) break;
            b = bq.pop_front();
            push(s, b);
            #1;
            hwdata = b.wdata;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
        hsize = 3'd0; hburst = 3'd0; hwdata = '0; dsel = 0;

        #2 hresetn = 1'b0;
        #1;
        chk("rst_hreadyout", {31'd0, bus0.HREADYOUT}, 32'd1);
        chk("rst_hresp", {30'd0, bus0.HRESP}, 32'd0);
        chk("rst_hrdata", bus0.HRDATA, 32'd0);
        chk("rst_hreadyout1", {31'd0, bus1.HREADYOUT}, 32'd1);
        repeat (2) @(posedge hclk);
        #1 hresetn = 1'b1;
        @(posedge hclk);
        #1;

        // zero-wait write then read
        low_cnt = 0;
        add(32'h010, 3'd2, 1'b1, 32'h11223344, HTRANS_NONSEQ);
        add(32'h010, 3'd2, 1'b0, 32'h0, HTRANS_NONSEQ);
        run(0);
        chk("t1_model_rd", last_rd, 32'h11223344);
        chk("t1_dut_rd", last_act, 32'h11223344);
        chk("t1_no_wait", low_cnt, 0);

        // byte and half lanes
        add(32'h020, 3'd2, 1'b1, 32'h00000000, HTRANS_NONSEQ);
        add(32'h021, 3'd0, 1'b1, 32'hAAAAAAAA, HTRANS_NONSEQ);
        add(32'h022, 3'd1, 1'b1, 32'hBEEFBEEF, HTRANS_NONSEQ);
        add(32'h020, 3'd2, 1'b0, 32'h0, HTRANS_NONSEQ);
        run(0);
        chk("t2_model_rd", last_rd, 32'hBEEFAA00);
        chk("t2_dut_rd", last_act, 32'hBEEFAA00);

        // wait states on an INCR4 burst
        hburst = 3'b011;
        add(32'h100, 3'd2, 1'b1, 32'hA0A1A2A3, HTRANS_NONSEQ);
        add(32'h104, 3'd2, 1'b1, 32'hB0B1B2B3, HTRANS_SEQ);
        add(32'h108, 3'd2, 1'b1, 32'hC0C1C2C3, HTRANS_SEQ);
        add(32'h10C, 3'd2, 1'b1, 32'hD0D1D2D3, HTRANS_SEQ);
        run(1);
        low_cnt = 0;
        add(32'h100, 3'd2, 1'b0, 32'h0, HTRANS_NONSEQ);
        add(32'h104, 3'd2, 1'b0, 32'h0, HTRANS_SEQ);
        add(32'h108, 3'd2, 1'b0, 32'h0, HTRANS_SEQ);
        add(32'h10C, 3'd2, 1'b0, 32'h0, HTRANS_SEQ);
        run(1);
        hburst = 3'b000;
        chk("t3_wait_cycles", low_cnt, 5);
        chk("t3_model_last", last_rd, 32'hD0D1D2D3);
        chk("t3_dut_last", last_act, 32'hD0D1D2D3);

        // illegal transfers
        add(32'h000, 3'd2, 1'b1, 32'h55667788, HTRANS_NONSEQ);
        run(0);
        err_cnt = 0;
        low_cnt = 0;
        add(32'h003, 3'd2, 1'b1, 32'hDEADBEEF, HTRANS_NONSEQ);
        run(0);
        chk("t4_err_cycles", err_cnt, 2);
        chk("t4_err_stall", low_cnt, 1);
        add(32'h000, 3'd2, 1'b0, 32'h0, HTRANS_NONSEQ);
        run(0);
        chk("t4_model_keep", last_rd, 32'h55667788);
        chk("t4_dut_keep", last_act, 32'h55667788);
        err_cnt = 0;
        add(32'h000, 3'd3, 1'b1, 32'hDEADBEEF, HTRANS_NONSEQ);
        add(32'h001, 3'd1, 1'b1, 32'hDEADBEEF, HTRANS_NONSEQ);
        add(32'h000, 3'd2, 1'b0, 32'h0, HTRANS_NONSEQ);
        run(0);
        chk("t4_err_cycles2", err_cnt, 4);
        chk("t4_dut_keep2", last_act, 32'h55667788);

        // address wrap and back-to-back write/read
        add(32'h404, 3'd2, 1'b1, 32'hA5A55A5A, HTRANS_NONSEQ);
        run(0);
        add(32'h004, 3'd2, 1'b0, 32'h0, HTRANS_NONSEQ);
        run(0);
        chk("t5_wrap_model", last_rd, 32'hA5A55A5A);
        chk("t5_wrap_dut", last_act, 32'hA5A55A5A);
        add(32'h008, 3'd2, 1'b1, 32'h01020304, HTRANS_NONSEQ);
        add(32'h008, 3'd2, 1'b0, 32'h0, HTRANS_NONSEQ);
        run(0);
        chk("t5_b2b_dut", last_act, 32'h01020304);

        // reset during a write wait state
        add(32'h040, 3'd2, 1'b1, 32'hCAFEF00D, HTRANS_NONSEQ);
        run(1);
        dsel = 1; hsel = 1'b1; haddr = 32'h040; htrans = HTRANS_NONSEQ;
        hwrite = 1'b1; hsize = 3'd2;
        @(negedge hclk);
        @(posedge hclk);
        push(1, '{addr: 32'h040, size: 3'd2, wr: 1'b1, wdata: 32'h12345678, trans: HTRANS_NONSEQ});
        #1;
        hwdata = 32'h12345678;
        hsel = 1'b0;
        htrans = HTRANS_IDLE;
        @(negedge hclk);
        #1;
        chk("t6_in_wait", {31'd0, bus1.HREADYOUT}, 32'd0);
        #1 hresetn = 1'b0;
        eq.delete();
        #1;
        chk("t6_rst_hreadyout", {31'd0, bus1.HREADYOUT}, 32'd1);
        chk("t6_rst_hresp", {30'd0, bus1.HRESP}, 32'd0);
        chk("t6_rst_hrdata", bus1.HRDATA, 32'd0);
        repeat (2) @(posedge hclk);
        #1 hresetn = 1'b1;
        @(posedge hclk);
        #1;
        add(32'h040, 3'd2, 1'b0, 32'h0, HTRANS_NONSEQ);
        run(1);
        chk("t6_model_keep", last_rd, 32'hCAFEF00D);
        chk("t6_dut_keep", last_act, 32'hCAFEF00D);

        repeat (2) @(posedge hclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
